// File: rtl/mem_arb.sv
// mem_arb: shares one single-port synchronous RAM between the CPU and loader ports.
// Define MEM_ARB_LD_PRIO_EN to give the loader fixed priority instead of round-robin.
module mem_arb #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int NP = 2;  // port index: 0 = CPU, 1 = LD

  typedef enum logic [1:0] {IDLE, ACC, CAPT} state_t;

  state_t                    state_q, state_d;
  logic                      owner_q, owner_d;
  logic                      mem_en_q, mem_en_d;
  logic                      mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]         mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]         mem_wdata_q, mem_wdata_d;
  logic [NP-1:0]             gnt_q, gnt_d;
  logic [NP-1:0]             rvalid_q, rvalid_d;
  logic [NP-1:0][DATA_W-1:0] rdata_q, rdata_d;
  logic                      pick_ld;

`ifdef MEM_ARB_LD_PRIO_EN
  assign pick_ld = ld_req;
`else
  logic last_q, last_d;  // 1: loader held the most recent grant

  assign pick_ld = ld_req & (~cpu_req | ~last_q);

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && (cpu_req || ld_req)) last_d = pick_ld;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    rdata_d     = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req || ld_req) begin
          owner_d        = pick_ld;
          mem_en_d       = 1'b1;
          mem_we_d       = pick_ld ? ld_we    : cpu_we;
          mem_addr_d     = pick_ld ? ld_addr  : cpu_addr;
          mem_wdata_d    = pick_ld ? ld_wdata : cpu_wdata;
          gnt_d[pick_ld] = 1'b1;
          state_d        = ACC;
        end
      end
      // mem_we_q still carries the access type while the RAM samples the strobe
      ACC:  state_d = mem_we_q ? IDLE : CAPT;
      CAPT: begin
        rdata_d[owner_q]  = mem_rdata;
        rvalid_d[owner_q] = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign cpu_gnt    = gnt_q[0];
  assign ld_gnt     = gnt_q[1];
  assign cpu_rvalid = rvalid_q[0];
  assign ld_rvalid  = rvalid_q[1];
  assign cpu_rdata  = rdata_q[0];
  assign ld_rdata   = rdata_q[1];
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = (state_q != IDLE);

endmodule
